// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: fetch-sequencer state encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2,
    FS_HALT  = 2'd3
  } fetch_state_t;

  // Default geometry of the core.
  localparam int          CPU_PC_WIDTH    = 8;
  localparam int          CPU_INSTR_WIDTH = 16;
  localparam logic [7:0]  CPU_RESET_PC    = 8'h00;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux: branch target when a branch is taken, otherwise the sequential PC+1.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is loaded.
//
// Ports:
//   branchTaken  - select the branch target
//   branchTarget - target from the branch-target adder
//   PCAdded      - sequential successor (pc+1)
//   next_pc      - selected next program counter
module pc_next_sel #(
  parameter int PC_WIDTH = 8
) (
  input  logic                branchTaken,
  input  logic [PC_WIDTH-1:0] branchTarget,
  input  logic [PC_WIDTH-1:0] PCAdded,
  output logic [PC_WIDTH-1:0] next_pc
);

  assign next_pc = branchTaken ? branchTarget : PCAdded;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and req/ack instruction-fetch sequencer feeding decode over valid/ready.
// Latency: run->imemReq 1 cycle, ack->instrValid 1 cycle, accept->new pc/imemReq 1 cycle.
// Backpressure: instr held stable until instrReady; no new fetch is issued before accept.
//
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   run, haltReq                 - start level / stop-after-current-instruction pulse
//   imemReq, imemAddr            - fetch request and address (address is pc)
//   imemAck, imemData            - memory response
//   instr, instrValid, instrReady - registered instruction to decode, handshake
//   branchTaken, branchTarget    - next-PC selection, sampled on accept
//   PCAdded, pc, halted          - pc+1, current pc, halt status
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH    = CPU_PC_WIDTH,
  parameter int                  INSTR_WIDTH = CPU_INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(CPU_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   haltReq,
  output logic                   imemReq,
  output logic [PC_WIDTH-1:0]    imemAddr,
  input  logic                   imemAck,
  input  logic [INSTR_WIDTH-1:0] imemData,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instrValid,
  input  logic                   instrReady,
  input  logic                   branchTaken,
  input  logic [PC_WIDTH-1:0]    branchTarget,
  output logic [PC_WIDTH-1:0]    PCAdded,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   halted
);

  fetch_state_t          state;
  logic                  halt_pend;
  logic [PC_WIDTH-1:0]   next_pc;
  logic                  accept;

  // Moore outputs straight from the state register, so a reset drops
  // imemReq/instrValid asynchronously and a later ack finds us in IDLE.
  assign imemReq    = (state == FS_FETCH);
  assign instrValid = (state == FS_HOLD);
  assign halted     = (state == FS_HALT);

  assign imemAddr = pc;
  assign PCAdded  = pc + PC_WIDTH'(1);  // wraps FF->00 silently
  assign accept   = instrValid & instrReady;

  pc_next_sel #(
    .PC_WIDTH (PC_WIDTH)
  ) u_next_sel (
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .PCAdded      (PCAdded),
    .next_pc      (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FS_IDLE;
      pc        <= RESET_PC;
      instr     <= '0;
      halt_pend <= 1'b0;
    end else begin
      case (state)
        FS_IDLE, FS_HALT: begin
          // A simultaneous haltReq keeps us parked.
          if (run && !haltReq) state <= FS_FETCH;
        end

        FS_FETCH: begin
          // The in-flight fetch always completes; a halt only takes effect
          // after the fetched instruction has been accepted.
          if (haltReq) halt_pend <= 1'b1;
          if (imemAck) begin
            instr <= imemData;
            state <= FS_HOLD;
          end
        end

        FS_HOLD: begin
          if (accept) begin
            pc <= next_pc;
            // haltReq coincident with accept applies to this accept.
            if (halt_pend || haltReq) begin
              state     <= FS_HALT;
              halt_pend <= 1'b0;
            end else begin
              state <= FS_FETCH;
            end
          end else if (haltReq) begin
            halt_pend <= 1'b1;
          end
        end

        default: state <= FS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: the driver pushes {instr, pc} on every ack,
// the monitor pops and compares on every accepted instruction.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, haltReq;
  logic        imemReq;
  logic [7:0]  imemAddr;
  logic        imemAck;
  logic [15:0] imemData;
  logic [15:0] instr;
  logic        instrValid, instrReady;
  logic        branchTaken;
  logic [7:0]  branchTarget;
  logic [7:0]  PCAdded, pc;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  addr;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .haltReq      (haltReq),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemAck      (imemAck),
    .imemData     (imemData),
    .instr        (instr),
    .instrValid   (instrValid),
    .instrReady   (instrReady),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .PCAdded      (PCAdded),
    .pc           (pc),
    .halted       (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted instruction must match the oldest outstanding ack.
  always @(negedge clk) begin
    if (rst_n && instrValid === 1'b1 && instrReady === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: accepted instr %0h at pc %0h with nothing expected", instr, pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_cmp++;
        if (instr !== e.data || pc !== e.addr) begin
          n_err++;
          $display("FAIL sb_accept: got instr %0h pc %0h expected instr %0h pc %0h",
                   instr, pc, e.data, e.addr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction: wait for the request, ack after ack_lat cycles, hold ready
  // low for rdy_lat cycles, then accept with the given branch inputs.
  // halt_mode: 0 none, 1 haltReq pulse during FETCH, 2 haltReq with the accept.
  task automatic fetch_one(input logic [15:0] data, input int ack_lat, input int rdy_lat,
                           input logic br, input logic [7:0] tgt, input logic [7:0] exp_pc,
                           input logic [7:0] exp_next, input int halt_mode);
    int waited = 0;
    while (imemReq !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    if (imemReq !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_timeout: imemReq %b expected 1 within 20 cycles", imemReq);
      return;
    end
    check("imem_addr", 32'(imemAddr), 32'(exp_pc));
    for (int i = 0; i < ack_lat; i++) begin
      if (halt_mode == 1 && i == 0) haltReq = 1'b1;
      check("req_held", 32'(imemReq), 32'd1);
      check("no_valid_in_fetch", 32'(instrValid), 32'd0);
      step();
      haltReq = 1'b0;
    end
    imemAck  = 1'b1;
    imemData = data;
    sb_q.push_back('{data: data, addr: exp_pc});
    step();
    imemAck  = 1'b0;
    imemData = 16'h0000;
    check("valid_after_ack", 32'(instrValid), 32'd1);
    for (int i = 0; i < rdy_lat; i++) begin
      check("instr_stable", 32'(instr), 32'(data));
      check("no_fetch_before_accept", 32'(imemReq), 32'd0);
      step();
    end
    instrReady   = 1'b1;
    branchTaken  = br;
    branchTarget = tgt;
    if (halt_mode == 2) haltReq = 1'b1;
    step();
    instrReady   = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = 8'h00;
    haltReq      = 1'b0;
    check("pc_after_accept", 32'(pc), 32'(exp_next));
    check("halted_after_accept", 32'(halted), (halt_mode != 0) ? 32'd1 : 32'd0);
    check("req_after_accept", 32'(imemReq), (halt_mode != 0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; haltReq = 1'b0; imemAck = 1'b0; imemData = 16'h0;
    instrReady = 1'b0; branchTaken = 1'b0; branchTarget = 8'h00;
    #12;
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_req", 32'(imemReq), 32'd0);
    check("rst_valid", 32'(instrValid), 32'd0);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_no_req", 32'(imemReq), 32'd0);

    // First fetch
    run = 1'b1;
    step();
    run = 1'b0;
    check("req_after_run", 32'(imemReq), 32'd1);
    fetch_one(16'hA5A5, 0, 0, 1'b0, 8'h00, 8'h00, 8'h01, 0);

    // Sequential stream with ack latency and decode backpressure
    fetch_one(16'h1111, 2, 3, 1'b0, 8'h00, 8'h01, 8'h02, 0);
    fetch_one(16'h2222, 1, 0, 1'b0, 8'h77, 8'h02, 8'h03, 0);
    fetch_one(16'h3333, 0, 1, 1'b0, 8'h00, 8'h03, 8'h04, 0);
    fetch_one(16'h4444, 0, 0, 1'b0, 8'h00, 8'h04, 8'h05, 0);

    // Taken branch at 05 -> 40, back to 05, then not-taken -> 06
    fetch_one(16'h5555, 0, 0, 1'b1, 8'h40, 8'h05, 8'h40, 0);
    check("addr_follows_branch", 32'(imemAddr), 32'h40);
    fetch_one(16'h4040, 1, 0, 1'b1, 8'h05, 8'h40, 8'h05, 0);
    fetch_one(16'h5556, 0, 0, 1'b0, 8'h40, 8'h05, 8'h06, 0);

    // Wrap-around FF -> 00
    fetch_one(16'h6666, 0, 0, 1'b1, 8'hFF, 8'h06, 8'hFF, 0);
    check("padded_at_ff", 32'(PCAdded), 32'h00);
    fetch_one(16'hFFFF, 0, 0, 1'b0, 8'h00, 8'hFF, 8'h00, 0);
    check("padded_after_wrap", 32'(PCAdded), 32'h01);

    // Halt requested during FETCH: fetch completes, then HALT
    fetch_one(16'hBEEF, 2, 1, 1'b0, 8'h00, 8'h00, 8'h01, 1);

    // run + haltReq together in HALT stays halted
    run = 1'b1; haltReq = 1'b1;
    step();
    run = 1'b0; haltReq = 1'b0;
    check("halt_wins_halted", 32'(halted), 32'd1);
    check("halt_wins_req", 32'(imemReq), 32'd0);

    // run alone resumes at saved pc
    run = 1'b1;
    step();
    run = 1'b0;
    check("resume_req", 32'(imemReq), 32'd1);
    check("resume_halted", 32'(halted), 32'd0);
    // haltReq coincident with accept
    fetch_one(16'hC0DE, 0, 2, 1'b0, 8'h00, 8'h01, 8'h02, 2);
    step();
    check("stay_halted", 32'(halted), 32'd1);

    // Asynchronous reset mid-fetch
    run = 1'b1;
    step();
    run = 1'b0;
    check("req_before_reset", 32'(imemReq), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("req_drops_async", 32'(imemReq), 32'd0);
    check("pc_async_reset", 32'(pc), 32'h00);
    imemAck = 1'b1; imemData = 16'hDEAD;
    step();
    rst_n = 1'b1;
    step();
    step();
    imemAck = 1'b0;
    check("stray_ack_no_valid", 32'(instrValid), 32'd0);
    check("stray_ack_no_req", 32'(imemReq), 32'd0);
    check("post_reset_instr", 32'(instr), 32'h0);
    check("post_reset_pc", 32'(pc), 32'h00);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
